// File: rtl/branch_pc_unit.sv
// PC register and branch resolver: decides taken/not-taken, computes the next PC,
// offers PCs to fetch over valid/ready, traps on misaligned targets, counts retires.
module branch_pc_unit #(
   parameter int                 WIDTH    = 32,
   parameter logic [WIDTH-1:0]   RESET_PC = 32'h8000_0000,
   parameter int                 CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CTRL_i_branch,
   input  logic              CTRL_i_jal,
   input  logic              CTRL_i_jalr,
   input  logic [2:0]        CTRL_i_funct3,
   output logic              CTRL_o_br_un,
   input  logic              BR_JMP_i_br_eq,
   input  logic              BR_JMP_i_br_lt,
   input  logic [WIDTH-1:0]  IDU_i_imm,
   input  logic [WIDTH-1:0]  IDU_i_valA,
   input  logic              EXU_i_valid,
   input  logic              IFU_i_ready,
   output logic [WIDTH-1:0]  PC_o_pc,
   output logic              PC_o_valid,
   output logic [WIDTH-1:0]  PC_o_snpc,
   output logic              PC_o_taken,
   output logic              PC_o_trap,
   output logic [WIDTH-1:0]  PC_o_badaddr,
   output logic [CNT_W-1:0]  PC_o_retired,
   output logic [CNT_W-1:0]  PC_o_br_taken
);

   // state    | meaning
   // ST_ISSUE | PC offered to fetch, waiting for ready
   // ST_WAIT  | PC accepted, waiting for the instruction to commit
   // ST_TRAP  | misaligned target seen, frozen until reset
   typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_TRAP} state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    pc_q, pc_d;
   logic                trap_q, trap_d;
   logic [WIDTH-1:0]    badaddr_q, badaddr_d;
   logic [CNT_W-1:0]    retired_q, retired_d;
   logic [CNT_W-1:0]    br_taken_q, br_taken_d;

   logic                br_cond;
   logic                br_hit;
   logic [WIDTH-1:0]    jalr_sum;
   logic [WIDTH-1:0]    target;
   logic                misaligned;

   always_comb begin
      br_cond = 1'b0;
      case (CTRL_i_funct3)
         3'b000:          br_cond = BR_JMP_i_br_eq;
         3'b001:          br_cond = !BR_JMP_i_br_eq;
         3'b100, 3'b110:  br_cond = BR_JMP_i_br_lt;
         3'b101, 3'b111:  br_cond = !BR_JMP_i_br_lt;
         default:         br_cond = 1'b0;
      endcase
   end

   assign br_hit       = CTRL_i_branch && br_cond;
   assign jalr_sum     = IDU_i_valA + IDU_i_imm;
   assign CTRL_o_br_un = CTRL_i_funct3[1];
   assign PC_o_taken   = CTRL_i_jalr || CTRL_i_jal || br_hit;
   assign PC_o_snpc    = pc_q + WIDTH'(4);

   always_comb begin
      if (CTRL_i_jalr)
         target = {jalr_sum[WIDTH-1:1], 1'b0};
      else if (CTRL_i_jal || br_hit)
         target = pc_q + IDU_i_imm;
      else
         target = PC_o_snpc;
   end

   // Sequential fall-through is aligned by construction; only redirects can fault.
   assign misaligned = PC_o_taken && (target[1:0] != 2'b00);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      trap_d     = trap_q;
      badaddr_d  = badaddr_q;
      retired_d  = retired_q;
      br_taken_d = br_taken_q;
      case (state_q)
         ST_ISSUE: begin
            if (IFU_i_ready)
               state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (EXU_i_valid) begin
               if (misaligned) begin
                  state_d   = ST_TRAP;
                  trap_d    = 1'b1;
                  badaddr_d = target;
               end else begin
                  state_d   = ST_ISSUE;
                  pc_d      = target;
                  retired_d = retired_q + CNT_W'(1);
                  if (br_hit && !CTRL_i_jal && !CTRL_i_jalr)
                     br_taken_d = br_taken_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_ISSUE;
         pc_q       <= RESET_PC;
         trap_q     <= 1'b0;
         badaddr_q  <= '0;
         retired_q  <= '0;
         br_taken_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         trap_q     <= trap_d;
         badaddr_q  <= badaddr_d;
         retired_q  <= retired_d;
         br_taken_q <= br_taken_d;
      end
   end

   assign PC_o_pc       = pc_q;
   assign PC_o_valid    = (state_q == ST_ISSUE);
   assign PC_o_trap     = trap_q;
   assign PC_o_badaddr  = badaddr_q;
   assign PC_o_retired  = retired_q;
   assign PC_o_br_taken = br_taken_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Scoreboard bench for branch_pc_unit: commits push the expected next PC/counters,
// a monitor pops and compares on every fetch handshake or trap entry.
module tb_branch_pc_unit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        br = 1'b0, jal = 1'b0, jalr = 1'b0;
   logic [2:0]  f3 = 3'b000;
   logic        br_un;
   logic        eq = 1'b0, lt = 1'b0;
   logic [31:0] imm = '0, vala = '0;
   logic        exu_valid = 1'b0, ifu_ready = 1'b0;
   logic [31:0] pc, snpc, badaddr;
   logic        pc_valid, taken, trap;
   logic [3:0]  retired, br_taken;

   always #5 clk = ~clk;

   branch_pc_unit #(.WIDTH(32), .RESET_PC(RST_PC), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .CTRL_i_branch(br), .CTRL_i_jal(jal), .CTRL_i_jalr(jalr),
      .CTRL_i_funct3(f3), .CTRL_o_br_un(br_un),
      .BR_JMP_i_br_eq(eq), .BR_JMP_i_br_lt(lt),
      .IDU_i_imm(imm), .IDU_i_valA(vala),
      .EXU_i_valid(exu_valid), .IFU_i_ready(ifu_ready),
      .PC_o_pc(pc), .PC_o_valid(pc_valid), .PC_o_snpc(snpc),
      .PC_o_taken(taken), .PC_o_trap(trap), .PC_o_badaddr(badaddr),
      .PC_o_retired(retired), .PC_o_br_taken(br_taken)
   );

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  ret;
      logic [3:0]  brt;
      logic        trap;
      logic [31:0] bad;
   } exp_t;

   exp_t        sb_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] m_pc  = RST_PC;
   logic [3:0]  m_ret = '0;
   logic [3:0]  m_brt = '0;
   logic        prev_trap = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a handshake or trap entry is the DUT presenting a result.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && ((pc_valid && ifu_ready) || (trap && !prev_trap))) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: output at pc 0x%08h with empty queue", pc);
         end else begin
            e = sb_q.pop_front();
            check("sb_pc",       pc,             e.pc);
            check("sb_retired",  32'(retired),   32'(e.ret));
            check("sb_br_taken", 32'(br_taken),  32'(e.brt));
            check("sb_trap",     32'(trap),      32'(e.trap));
            check("sb_badaddr",  badaddr,        e.bad);
         end
      end
      prev_trap = trap;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctrl();
      br = 1'b0; jal = 1'b0; jalr = 1'b0; f3 = 3'b000;
      eq = 1'b0; lt = 1'b0; imm = '0; vala = '0;
   endtask

   task automatic do_reset(input logic with_exu);
      rst = 1'b1;
      ifu_ready = 1'b0;
      exu_valid = with_exu;
      tick();
      rst = 1'b0;
      exu_valid = 1'b0;
      clear_ctrl();
      m_pc = RST_PC; m_ret = '0; m_brt = '0;
      sb_q.push_back('{pc: RST_PC, ret: 4'd0, brt: 4'd0, trap: 1'b0, bad: 32'h0});
   endtask

   task automatic fetch();
      int n = 0;
      while (!pc_valid && n < 20) begin
         tick();
         n++;
      end
      if (!pc_valid) check("fetch_timeout", 32'(pc_valid), 32'd1);
      ifu_ready = 1'b1;
      tick();
      ifu_ready = 1'b0;
      check("valid_drop", 32'(pc_valid), 32'd0);
   endtask

   task automatic commit(input logic c_br, input logic c_jal, input logic c_jalr,
                         input logic [2:0] c_f3, input logic c_eq, input logic c_lt,
                         input logic [31:0] c_imm, input logic [31:0] c_vala,
                         input logic [31:0] exp_next, input logic exp_taken,
                         input logic exp_brinc, input logic exp_trap);
      br = c_br; jal = c_jal; jalr = c_jalr; f3 = c_f3;
      eq = c_eq; lt = c_lt; imm = c_imm; vala = c_vala;
      exu_valid = 1'b1;
      #1;
      check("taken", 32'(taken), 32'(exp_taken));
      check("br_un", 32'(br_un), 32'(c_f3[1]));
      check("snpc",  snpc,       m_pc + 32'd4);
      @(posedge clk);
      #1;
      exu_valid = 1'b0;
      clear_ctrl();
      if (exp_trap) begin
         sb_q.push_back('{pc: m_pc, ret: m_ret, brt: m_brt, trap: 1'b1, bad: exp_next});
      end else begin
         m_pc = exp_next;
         m_ret = m_ret + 4'd1;
         if (exp_brinc) m_brt = m_brt + 4'd1;
         sb_q.push_back('{pc: m_pc, ret: m_ret, brt: m_brt, trap: 1'b0, bad: 32'h0});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset(1'b0);
      check("rst_valid",   32'(pc_valid), 32'd1);
      check("rst_pc",      pc,            RST_PC);
      check("rst_trap",    32'(trap),     32'd0);
      check("rst_badaddr", badaddr,       32'h0);
      check("rst_retired", 32'(retired),  32'd0);
      check("rst_brt",     32'(br_taken), 32'd0);

      // Sequential flow; valid must stay low through every WAIT cycle.
      fetch();
      tick();
      check("wait_valid1", 32'(pc_valid), 32'd0);
      tick();
      check("wait_valid2", 32'(pc_valid), 32'd0);
      commit(0,0,0, 3'b000, 0,0, 32'h0, 32'h0, 32'h8000_0004, 0, 0, 0);
      fetch();

      do_reset(1'b0);
      fetch();
      commit(1,0,0, 3'b000, 1,0, 32'h10,        32'h0, 32'h8000_0010, 1, 1, 0); // BEQ taken
      fetch();
      commit(1,0,0, 3'b110, 0,1, 32'hFFFF_FFF8, 32'h0, 32'h8000_0008, 1, 1, 0); // BLTU taken back
      fetch();
      commit(1,0,0, 3'b001, 1,0, 32'h10,        32'h0, 32'h8000_000C, 0, 0, 0); // BNE not taken
      fetch();
      commit(1,0,0, 3'b011, 0,1, 32'h40,        32'h0, 32'h8000_0010, 0, 0, 0); // funct3 011 never taken
      fetch();
      commit(1,0,0, 3'b101, 0,0, 32'h20,        32'h0, 32'h8000_0030, 1, 1, 0); // BGE taken
      fetch();
      commit(1,1,0, 3'b000, 1,0, 32'h100,       32'h0, 32'h8000_0130, 1, 0, 0); // JAL wins, no br count
      fetch();
      commit(0,1,1, 3'b000, 0,0, 32'h0, 32'h8000_0201, 32'h8000_0200, 1, 0, 0); // JALR clears bit 0

      // Fetch stalled: commits in ISSUE must be ignored.
      br = 1'b1; f3 = 3'b000; eq = 1'b1; imm = 32'h10;
      for (int i = 0; i < 5; i++) begin
         exu_valid = ~exu_valid;
         tick();
      end
      exu_valid = 1'b0;
      clear_ctrl();
      check("hold_pc",      pc,            32'h8000_0200);
      check("hold_retired", 32'(retired),  32'd7);
      fetch();

      // Reset wins over a coincident (would-trap) commit.
      jalr = 1'b1; vala = 32'h8000_0103;
      do_reset(1'b1);
      check("rst_exu_trap", 32'(trap), 32'd0);
      fetch();

      commit(0,0,1, 3'b000, 0,0, 32'h0, 32'h8000_0103, 32'h8000_0102, 1, 0, 1);
      ifu_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exu_valid = ~exu_valid;
         tick();
         check("trap_valid", 32'(pc_valid), 32'd0);
      end
      ifu_ready = 1'b0;
      exu_valid = 1'b0;
      check("trap_pc",      pc,           RST_PC);
      check("trap_retired", 32'(retired), 32'd0);
      check("trap_held",    32'(trap),    32'd1);

      // 4-bit retire counter wraps to 0 on the 16th commit.
      do_reset(1'b0);
      for (int i = 0; i < 16; i++) begin
         fetch();
         commit(0,0,0, 3'b000, 0,0, 32'h0, 32'h0, m_pc + 32'd4, 0, 0, 0);
      end
      fetch();
      check("wrap_retired", 32'(retired), 32'd0);
      check("wrap_pc",      pc,           32'h8000_0040);

      tick();
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
